// File: rtl/uart_tx_frame_sched_if.sv
// uart_tx_frame_sched_if: requester, frame-status and transmitter signals of the frame scheduler
interface uart_tx_frame_sched_if #(parameter int NREQ = 4);
    logic [2:0]        baud_sel_i;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*8-1:0] req_len_i;
    logic [NREQ*8-1:0] req_data_i;
    logic [NREQ-1:0]   req_pop_o;
    logic [NREQ-1:0]   grant_o;
    logic [NREQ-1:0]   frame_done_o;
    logic              frame_err_o;
    logic              busy_o;
    logic              tx_start_o;
    logic [7:0]        tx_data_o;
    logic [3:0]        tx_baud_sel_o;
    logic              tx_done_i;
    modport master (
        input  baud_sel_i, req_i, req_len_i, req_data_i, tx_done_i,
        output req_pop_o, grant_o, frame_done_o, frame_err_o, busy_o, tx_start_o, tx_data_o, tx_baud_sel_o
    );
    modport slave (
        output baud_sel_i, req_i, req_len_i, req_data_i, tx_done_i,
        input  req_pop_o, grant_o, frame_done_o, frame_err_o, busy_o, tx_start_o, tx_data_o, tx_baud_sel_o
    );
endinterface

// File: rtl/uart_tx_frame_sched.sv
// uart_tx_frame_sched: round-robin framer sharing one uart_tx among NREQ requesters
module uart_tx_frame_sched #(
    parameter int         NREQ         = 4,
    parameter logic [7:0] HDR_BYTE     = 8'hAA,
    parameter int         TIMEOUT_CLKS = 2000000
) (
    input logic clk,
    input logic rst_n,
    uart_tx_frame_sched_if.master bus
);
    localparam int WW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [WW-1:0] TO = WW'(TIMEOUT_CLKS);
    localparam logic [2:0] LAST = 3'(NREQ - 1);
    typedef enum logic [2:0] {IDLE, ARB, HDR, ID, LEN, PAY, CSUM, END} state_t;
    state_t state, state_d;
    logic wait_q, found, byte_st, start, adv, tout;
    logic [WW-1:0] wd, wd_nxt;
    logic [7:0] cnt, len_q, csum, data_q, cur;
    logic [2:0] id_q, rr, win, idx;
    logic [3:0] sum, baud_q;
    logic [NREQ-1:0] grant_q, sh;
    // lowest rotated offset from rr wins, so scan downwards and keep the last hit
    always_comb begin
        found = 1'b0;
        win = '0;
        sum = '0;
        idx = '0;
        sh = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr} + 4'(i);
            idx = 3'(sum >= 4'(NREQ) ? sum - 4'(NREQ) : sum);
            sh = bus.req_i >> idx;
            if (sh[0]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    always_comb begin
        byte_st = state inside {HDR, ID, LEN, PAY, CSUM};
        start = byte_st && !wait_q;
        wd_nxt = wd + WW'(1);
        adv = byte_st && wait_q && bus.tx_done_i;
        tout = byte_st && wait_q && !bus.tx_done_i && wd_nxt == TO;
        cur = state == HDR ? HDR_BYTE :
              state == ID  ? {5'd0, id_q} :
              state == LEN ? len_q :
              state == PAY ? 8'(bus.req_data_i >> {id_q, 3'd0}) : csum;
        state_d = state;
        case (state)
            IDLE:    state_d = |bus.req_i ? ARB : IDLE;
            ARB:     state_d = found ? HDR : IDLE;
            HDR:     state_d = adv ? ID : HDR;
            ID:      state_d = adv ? LEN : ID;
            LEN:     state_d = adv ? (len_q == 8'd0 ? CSUM : PAY) : LEN;
            PAY:     state_d = adv ? (cnt == len_q ? CSUM : PAY) : PAY;
            CSUM:    state_d = adv ? END : CSUM;
            default: state_d = IDLE;
        endcase
        if (tout) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wait_q  <= 1'b0;
            wd      <= '0;
            cnt     <= '0;
            len_q   <= '0;
            csum    <= '0;
            data_q  <= '0;
            id_q    <= '0;
            rr      <= '0;
            grant_q <= '0;
            baud_q  <= '0;
        end else begin
            state  <= state_d;
            wait_q <= start || (wait_q && !adv && !tout);
            wd     <= start ? '0 : wait_q ? wd_nxt : wd;
            if (state == IDLE) baud_q <= {1'b0, bus.baud_sel_i};
            if (start) data_q <= cur;
            if (state == ARB) begin
                id_q    <= win;
                len_q   <= 8'(bus.req_len_i >> {win, 3'd0});
                grant_q <= found ? NREQ'(1) << win : '0;
                csum    <= '0;
                cnt     <= '0;
            end
            if (start && state inside {ID, LEN, PAY}) csum <= csum ^ cur;
            if (start && state == PAY) cnt <= cnt + 8'd1;
            if (state == END || tout) begin
                grant_q <= '0;
                rr      <= id_q == LAST ? '0 : id_q + 3'd1;
            end
        end
    end
    assign bus.tx_start_o    = start;
    assign bus.tx_data_o     = start ? cur : data_q;
    assign bus.req_pop_o     = (start && state == PAY) ? grant_q : '0;
    assign bus.frame_done_o  = state == END ? grant_q : '0;
    assign bus.frame_err_o   = tout;
    assign bus.grant_o       = grant_q;
    assign bus.busy_o        = |grant_q;
    assign bus.tx_baud_sel_o = baud_q;
endmodule

// File: tb/tb_uart_tx_frame_sched.sv
// tb_uart_tx_frame_sched: randomized frame traffic checked against a frame-level reference model
module tb_uart_tx_frame_sched;
    localparam int N = 4;
    localparam int TO = 50;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    uart_tx_frame_sched_if #(.NREQ(N)) bus ();
    uart_tx_frame_sched #(.NREQ(N), .HDR_BYTE(8'hAA), .TIMEOUT_CLKS(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_tests = 0, n_fail = 0;
    logic [7:0] pay [N][256];
    int len_cfg [N];
    int ptr [N];
    int rr_m = 0, fid = 0, nb = 0, fpops = 0, t0 = 0, cd = -1, cyc = 0;
    int frames_done = 0, errs = 0, rearm = 0;
    bit in_frame = 0, withhold = 0, lat50 = 0, expect_err = 0, chk_busy = 0;
    logic [N-1:0] pend_pop = '0, pend_drop = '0, pend_restart = '0;
    logic [7:0] expq [$];
    logic [7:0] last_byte = '0;
    int gseq [$];
    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int pick(int rr, logic [N-1:0] req);
        for (int i = 0; i < N; i++) if (req[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction
    task automatic set_req(int k, int len);
        len_cfg[k] = len;
        for (int j = 0; j < 256; j++) pay[k][j] = 8'($urandom);
        ptr[k] = 0;
        bus.req_len_i[8*k +: 8] = 8'(len);
    endtask
    task flush;
        in_frame = 0; cd = -1; bus.tx_done_i = 1'b0; rr_m = 0;
        pend_pop = '0; pend_drop = '0; pend_restart = '0;
        expect_err = 0; withhold = 0; chk_busy = 0; lat50 = 0;
        for (int k = 0; k < N; k++) ptr[k] = 0;
    endtask
    // reference frame: header, id, length, payload, xor of everything after the header
    task sample;
        logic [7:0] cs;
        if (chk_busy) begin
            check("busy_after_err", bus.busy_o, 0);
            chk_busy = 0;
        end
        if (bus.tx_start_o) begin
            if (!in_frame) begin
                in_frame = 1; nb = 0; fpops = 0;
                fid = pick(rr_m, bus.req_i);
                check("grant", bus.grant_o, fid < 0 ? 0 : 1 << fid);
                if (fid < 0) fid = 0;
                gseq.push_back(fid);
                cs = 8'(fid) ^ 8'(len_cfg[fid]);
                expq = {8'hAA, 8'(fid), 8'(len_cfg[fid])};
                for (int j = 0; j < len_cfg[fid]; j++) begin
                    expq.push_back(pay[fid][j]);
                    cs ^= pay[fid][j];
                end
                expq.push_back(cs);
            end
            if (nb < expq.size()) check("byte", bus.tx_data_o, expq[nb]);
            else check("extra_byte", nb, expq.size() - 1);
            last_byte = bus.tx_data_o;
            nb++;
            t0 = cyc;
            if (withhold && nb == 3) begin
                cd = -1; withhold = 0; expect_err = 1;
            end else if (lat50) begin
                cd = TO; lat50 = 0;
            end else cd = $urandom_range(1, 30);
        end
        if (bus.req_pop_o != 0) begin
            check("pop_owner", bus.req_pop_o, in_frame ? 1 << fid : 0);
            fpops += $countones(bus.req_pop_o);
            pend_pop = bus.req_pop_o;
        end
        if (bus.frame_done_o != 0) begin
            check("done_vec", bus.frame_done_o, in_frame ? 1 << fid : 0);
            check("frame_len", nb, expq.size());
            check("pops", fpops, len_cfg[fid]);
            frames_done++;
            rr_m = (fid + 1) % N;
            in_frame = 0;
            pend_restart[fid] = 1'b1;
            if (rearm > 0) rearm--;
            else pend_drop[fid] = 1'b1;
        end
        if (bus.frame_err_o) begin
            check("err_expected", expect_err, 1);
            check("err_delay", cyc - t0, TO);
            errs++;
            rr_m = (fid + 1) % N;
            in_frame = 0;
            pend_restart[fid] = 1'b1;
            expect_err = 0;
            chk_busy = 1;
        end
    endtask
    // requester queues and transmitter model: inputs change 1 time unit after the edge
    initial begin
        bus.tx_done_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) flush();
            else begin
                for (int k = 0; k < N; k++) begin
                    if (pend_pop[k] && ptr[k] < 255) ptr[k]++;
                    if (pend_restart[k]) ptr[k] = 0;
                    if (pend_drop[k]) bus.req_i[k] = 1'b0;
                end
                pend_pop = '0; pend_restart = '0; pend_drop = '0;
                if (cd > 0) cd--;
                bus.tx_done_i = (cd == 0);
                if (cd == 0) cd = -1;
            end
            for (int k = 0; k < N; k++) bus.req_data_i[8*k +: 8] = pay[k][ptr[k]];
            @(negedge clk);
            cyc++;
            if (rst_n) sample();
        end
    end
    task automatic wait_idle(string tag, int budget);
        int c = 0;
        @(negedge clk);
        while ((bus.req_i != 0 || bus.busy_o) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({"wait_", tag}, int'(c < budget), 1);
        repeat (3) @(negedge clk);
    endtask
    task automatic check_rst(string t);
        check({t, "_busy"}, bus.busy_o, 0);
        check({t, "_grant"}, bus.grant_o, 0);
        check({t, "_start"}, bus.tx_start_o, 0);
        check({t, "_data"}, bus.tx_data_o, 0);
        check({t, "_baud"}, bus.tx_baud_sel_o, 0);
        check({t, "_pop"}, bus.req_pop_o, 0);
        check({t, "_done"}, bus.frame_done_o, 0);
        check({t, "_err"}, bus.frame_err_o, 0);
    endtask
    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
    initial begin
        int first, e0, f0, c, mask;
        bus.req_i = '0;
        bus.req_len_i = '0;
        bus.baud_sel_i = 3'd0;
        for (int k = 0; k < N; k++) set_req(k, 0);
        repeat (3) @(negedge clk);
        check_rst("rst");
        rst_n = 1'b1;
        set_req(0, 3);
        pay[0][0] = 8'h11; pay[0][1] = 8'h22; pay[0][2] = 8'h33;
        bus.req_i = 4'b0001;
        wait_idle("single", 3000);
        check("csum_single", last_byte, 8'h03);
        set_req(2, 0);
        bus.req_i = 4'b0100;
        wait_idle("zero", 2000);
        check("csum_zero", last_byte, 8'h02);
        check("zero_len_bytes", nb, 4);
        first = rr_m;
        gseq.delete();
        for (int k = 0; k < N; k++) set_req(k, 1);
        rearm = 1;
        bus.req_i = '1;
        wait_idle("rr", 5000);
        check("rr_count", gseq.size(), 5);
        for (int i = 0; i < 5; i++) if (i < gseq.size()) check("rr_order", gseq[i], (first + i) % N);
        first = rr_m; e0 = errs; f0 = frames_done;
        gseq.delete();
        for (int k = 0; k < N; k++) set_req(k, $urandom_range(0, 6));
        withhold = 1;
        bus.req_i = '1;
        wait_idle("timeout", 6000);
        check("err_count", errs - e0, 1);
        check("frames_after_err", frames_done - f0, N);
        if (gseq.size() > 1) check("after_err_grant", gseq[1], (first + 1) % N);
        e0 = errs;
        set_req(3, 2);
        lat50 = 1;
        bus.req_i = 4'b1000;
        wait_idle("lat50", 3000);
        check("lat50_no_err", errs - e0, 0);
        for (int r = 0; r < 4; r++) begin
            mask = 1 << r;
            for (int k = 0; k < N; k++) begin
                set_req(k, $urandom_range(0, 24));
                if ($urandom_range(0, 1) == 1) mask |= 1 << k;
            end
            rearm = $urandom_range(0, 3);
            bus.req_i = N'(mask);
            wait_idle("random", 20000);
        end
        set_req(1, 255);
        bus.req_i = 4'b0010;
        wait_idle("long", 12000);
        check("long_bytes", nb, 259);
        bus.baud_sel_i = 3'd4;
        repeat (3) @(negedge clk);
        check("baud_idle", bus.tx_baud_sel_o, 4);
        set_req(0, 10);
        bus.req_i = 4'b0001;
        c = 0;
        while (!bus.busy_o && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("baud_busy_wait", int'(c < 100), 1);
        bus.baud_sel_i = 3'd7;
        c = 0;
        while (bus.frame_done_o == 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("baud_frozen", bus.tx_baud_sel_o, 4);
        repeat (3) @(negedge clk);
        check("baud_new", bus.tx_baud_sel_o, 7);
        wait_idle("baud", 1000);
        set_req(0, 40);
        bus.req_i = 4'b0001;
        c = 0;
        while (!bus.req_pop_o[0] && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("reach_pay", int'(c < 2000), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_rst("async_rst");
        f0 = frames_done; e0 = errs;
        repeat (2) @(negedge clk);
        check("rst_no_done", frames_done - f0, 0);
        check("rst_no_err", errs - e0, 0);
        gseq.delete();
        rst_n = 1'b1;
        wait_idle("post_rst", 3000);
        check("post_rst_frames", frames_done - f0, 1);
        if (gseq.size() > 0) check("post_rst_grant", gseq[0], 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame_sched.md
Name: uart_tx_frame_sched

Overview:
- Round-robin scheduler sharing one uart_tx byte transmitter among NREQ requesters (radar result, status and debug sources).
- Each granted requester has its payload wrapped in a frame: 0xAA header, channel id, length, payload bytes, XOR checksum.
- The block drives the transmitter's start/data/baud inputs and paces bytes on its tx-done interrupt pulse.
- A watchdog aborts a frame if the transmitter stalls.

Parameters:
- NREQ, 4, number of requesters (2..8); ids 0..NREQ-1.
- HDR_BYTE, 8'hAA, frame header value.
- TIMEOUT_CLKS, 2000000, max cycles from tx_start to tx_done before abort; counter width clog2(TIMEOUT_CLKS+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- baud_sel_i  in  3  requested baud code 0..7
- req_i  in  NREQ  per-requester frame request level
- req_len_i  in  NREQ*8  payload length of requester k at bits [8k+7:8k]; 0..255
- req_data_i  in  NREQ*8  current payload byte (first-word-fall-through) of requester k
- req_pop_o  out  NREQ  one-cycle pulse: payload byte of requester k consumed
- grant_o  out  NREQ  one-hot owner of current frame; 0 when idle
- frame_done_o  out  NREQ  one-cycle pulse: frame of requester k fully sent
- frame_err_o  out  1  one-cycle pulse: frame aborted on timeout
- busy_o  out  1  high from grant until frame end/abort
- tx_start_o  out  1  one-cycle start pulse to transmitter
- tx_data_o  out  8  byte to transmit
- tx_baud_sel_o  out  4  baud select to transmitter, {1'b0, code}
- tx_done_i  in  1  one-cycle transmitter done interrupt

Behaviour:
- Reset values: all outputs 0 except tx_baud_sel_o = 4'd0; rr pointer = 0; state IDLE. Reset mid-frame abandons the frame immediately; no done/err pulse.
- tx_baud_sel_o is loaded from baud_sel_i only in IDLE; it is frozen while busy_o = 1.
- FSM: IDLE -> ARB -> HDR -> ID -> LEN -> (PAY if len != 0) -> CSUM -> END -> IDLE.
- IDLE: enter ARB when any req_i is set.
- ARB (1 cycle):
  - Search starts at the rr pointer and wraps. The first set bit wins and sets grant_o.
  - The winner's length is latched; busy_o = 1.
  - Later changes to req_i, req_len_i or the requester's dropping of req are ignored until the frame ends.
- Byte sub-sequence (HDR/ID/LEN/PAY/CSUM):
  - On the first cycle of the state, tx_data_o is loaded and tx_start_o pulses for exactly 1 cycle.
  - tx_data_o is then held stable until tx_done_i.
  - On tx_done_i, move to the next byte; the next tx_start_o follows 1 cycle later.
  - tx_done_i outside a wait is ignored.
- Byte values:
  - HDR: HDR_BYTE.
  - ID: {5'd0, id}.
  - LEN: latched length.
  - PAY: req_data_i[k] sampled on the start cycle, with a req_pop_o[k] pulse on that same cycle. Repeat until the 8-bit byte counter reaches the latched length.
  - CSUM: XOR of ID, LEN and all payload bytes (header excluded).
- Checksum register: cleared in ARB, updated as each byte is issued, 8-bit wraparound.
- END (1 cycle):
  - frame_done_o[k] pulses; grant_o and busy_o clear.
  - rr pointer <= (k+1) mod NREQ.
  - Return to IDLE; the next arbitration starts no earlier than the following cycle.
- Timeout:
  - The watchdog is cleared on each tx_start_o and counts while waiting.
  - When it reaches TIMEOUT_CLKS with no tx_done_i: frame_err_o pulses, grant/busy clear, go to IDLE, and the rr pointer advances past k.
  - If tx_done_i arrives on the same cycle as expiry, the done wins and there is no error.
- Simultaneous requests are resolved by rr order only. A requester holding req continuously is granted again only after the other active requesters have had a turn.
- len = 255 sends 259 bytes total; the byte counter must not overflow before comparison.

Test Plan:
- Single frame, 3 bytes: req0 len=3, data 11,22,33; model tx_done 100 clk after each start.
  - Expected tx bytes: AA,00,03,11,22,33,CSUM 0x03^0x11^0x22^0x33 = 0x03.
  - Expected pulses: 3 pops, frame_done_o = 0001.
- Zero length: req2 len=0.
  - Expected bytes: AA,02,00,02; no req_pop_o; frame_done_o = 0100.
- Round-robin: req_i = 1111 held, len=1 each.
  - Grants in order 0,1,2,3,0; one frame per requester before any repeats.
- Timeout: TIMEOUT_CLKS=50, withhold tx_done after the LEN byte.
  - Expected: frame_err_o pulses 50 clk after that start; busy_o falls; next frame grants the following requester.
- Baud freeze: baud_sel_i=4 in idle, changed to 7 mid-frame.
  - tx_baud_sel_o stays 4'd4 until END, then becomes 4'd7.
- Reset mid-frame: rst_n low during PAY.
  - All outputs return to reset values asynchronously; no done/err pulse; after release, a fresh frame starts with HDR from requester 0.
